alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder and computes the result for the CPU datapath. AND, OR, ADD and SUB finish in one cycle. MUL uses an iterative shift-add engine that stalls the pipeline through a valid/ready handshake. The block sits between the ID/EX register and the EX/MEM register; `ready_o` feeds the hazard/stall logic.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  unit can accept; an operation is accepted on a rising edge with `valid_i && ready_o`.
- `ALUCtrl_i`  in  3  operation code: 0 = AND, 1 = OR, 2 = ADD, 3 = SUB, 4 = MUL, 5–7 = illegal.
- `data1_i`  in  WIDTH  operand A.
- `data2_i`  in  WIDTH  operand B.
- `valid_o`  out  1  one-cycle pulse; the result registers were written on the previous edge.
- `data_o`  out  WIDTH  registered result; held until the next completion.
- `zero_o`  out  1  registered, equals `(data_o == 0)`; updated together with `data_o`.
- `illegal_o`  out  1  registered; set on completion of an illegal code, cleared on any legal completion.

## Operation
- There are two states: IDLE and MUL.
- `ready_o` = (state == IDLE) && !`rst_i`.
- **IDLE, accepted code 0–3:**
  - The result is written to `data_o`, `zero_o` and `illegal_o` on the accept edge.
  - `valid_o` is 1 for the following cycle.
  - The state stays IDLE, so back-to-back single-cycle operations sustain one per cycle.
- **IDLE, accepted code 4:**
  - On the accept edge, load multiplicand ← `data1_i`, multiplier ← `data2_i`, accumulator ← 0, count ← 0.
  - Go to MUL.
- **MUL, each edge:**
  - If multiplier[0] = 1, accumulator += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge where count == WIDTH−1, write the final accumulator to `data_o`, update `zero_o`, clear `illegal_o`, pulse `valid_o`, and return to IDLE.
- **IDLE, accepted code 5–7:**
  - `data_o` ← 0, `zero_o` ← 1, `illegal_o` ← 1.
  - `valid_o` pulses; no trap is raised.
- **Arithmetic:**
  - All results are modulo 2^WIDTH (ADD/SUB wrap, no overflow flag).
  - MUL returns the low WIDTH bits of the unsigned product, which equals the two's-complement low half.
- Inputs are ignored while in MUL; `valid_i` held high is not queued.
- `valid_o` is 0 in every cycle that does not immediately follow a completion edge.

## Timing
- Single-cycle operations: accept at edge k → `valid_o` high in the cycle after edge k (latency 1).
- MUL: accept at edge k; iterations occur on edges k+1 … k+WIDTH; `valid_o` is high after edge k+WIDTH (latency WIDTH+1).
- `ready_o` is low for exactly WIDTH cycles after a MUL accept.
- A new operation may be accepted in the same cycle that `valid_o` is high for the previous MUL.
- **Reset values:**
  - `data_o` = 0, `zero_o` = 0, `illegal_o` = 0, `valid_o` = 0.
  - State = IDLE; the count, multiplicand, multiplier and accumulator are all 0.
  - `ready_o` = 0 while `rst_i` is high.
- **Reset during MUL:** the operation is aborted, no `valid_o` is produced, and `ready_o` = 1 on the first cycle after `rst_i` falls.
- **`rst_i` and `valid_i` on the same edge:** reset wins; the request is not accepted.

## Configuration
- Macro `ALU_EXEC_MUL_EN`.
- **Defined:**
  - The MUL state and the iterative engine are compiled in.
  - Code 4 behaves as described above.
- **Undefined:**
  - The engine and the MUL state are removed; `ready_o` = !`rst_i` permanently.
  - Code 4 is treated as illegal: single cycle, `data_o` = 0, `zero_o` = 1, `illegal_o` = 1.

## Structure
- Package `alu_exec_pkg`:
  - Operation-code localparams ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_SUB = 3'd3, ALU_MUL = 3'd4.
  - The state encoding (IDLE = 1'b0, MUL = 1'b1).
- Sub-module `alu_exec_mul`: the iterative shift-add engine.
  - Ports: `clk_i`, `rst_i`, `start_i`, `a_i`, `b_i`, `done_o`, `product_o`.
  - Instantiated only under `ALU_EXEC_MUL_EN`.
- The top level holds the state register, the single-cycle datapath and the result/flag registers.

## Test plan
- Reset then idle → `data_o` = 0, `zero_o` = 0, `valid_o` = 0; `ready_o` = 0 during reset and 1 on the first cycle after.
- Back-to-back ADD 0x7FFFFFFF + 1, then SUB 5 − 5, then AND 0xF0F0 & 0x0FF0, then OR 0x1 | 0x2 → results 0x80000000, 0 (`zero_o` = 1), 0x00F0, 0x3 on four consecutive `valid_o` cycles.
- SUB 0 − 1 → 0xFFFFFFFF, `zero_o` = 0.
- MUL 7 × 6 (WIDTH = 32) → `ready_o` low for 32 cycles, `valid_o` 33 cycles after accept, `data_o` = 42.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- MUL 3 × 4 with `rst_i` asserted 10 cycles after accept → no `valid_o`, `data_o` = 0, and an immediate ADD 2 + 2 after reset → 4.
- Code 6 with operands 9, 9 → `data_o` = 0, `zero_o` = 1, `illegal_o` = 1.
- A following ADD clears `illegal_o`.
- With the macro undefined, code 4 on 3 × 3 → single cycle, `data_o` = 0, `illegal_o` = 1.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared opcodes and FSM encoding for the execution-stage ALU.
package alu_exec_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH iterations.
// product_o is the accumulator value that the current edge would write, so it is final while done_o is high.
module alu_exec_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done_o    = busy_q && (count_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      count_q  <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle AND/OR/ADD/SUB, optional iterative MUL behind valid/ready.
// Build macro ALU_EXEC_MUL_EN compiles in the MUL state and engine; without it code 4 is illegal.
//
// state | meaning
// IDLE  | ready; single-cycle ops complete on the accept edge
// MUL   | engine iterating, inputs ignored, ready_o low
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o
);

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic [WIDTH-1:0] res_d;
  logic             ill_d;

  assign accept = valid_i && ready_o;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (ALUCtrl_i)
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  state_t           state_q;
  state_t           state_d;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign ready_o = (state_q == IDLE) && !rst_i;

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    complete  = 1'b0;
    res_d     = alu_res;
    ill_d     = alu_illegal;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            complete = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          complete = 1'b1;
          res_d    = mul_product;
          ill_d    = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  alu_exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (data1_i),
    .b_i       (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`else
  assign ready_o = !rst_i;

  always_comb begin
    complete = accept;
    res_d    = alu_res;
    ill_d    = alu_illegal;
  end
`endif

  // Illegal codes leave alu_res at zero, so zero_o follows naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      data_o    <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o <= complete;
      if (complete) begin
        data_o    <= res_d;
        zero_o    <= (res_d == '0);
        illegal_o <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit; follows ALU_EXEC_MUL_EN the same way the RTL does.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int W = 32;

  logic         clk      = 1'b0;
  logic         rst_i    = 1'b1;
  logic         valid_i  = 1'b0;
  logic [2:0]   alu_ctrl = 3'd0;
  logic [W-1:0] d1       = '0;
  logic [W-1:0] d2       = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         zero_o;
  logic         illegal_o;

  typedef struct packed {
    logic [W-1:0] d;
    logic         z;
    logic         il;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_valid = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (d1),
    .data2_i   (d2),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .illegal_o (illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    logic [2*W-1:0] p;
    e.d  = '0;
    e.il = 1'b0;
    p    = '0;
    case (op)
      ALU_AND: e.d = a & b;
      ALU_OR:  e.d = a | b;
      ALU_ADD: e.d = a + b;
      ALU_SUB: e.d = a - b;
`ifdef ALU_EXEC_MUL_EN
      ALU_MUL: begin
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.d = p[W-1:0];
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.d == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid_o) begin
      exp_t e;
      n_valid++;
      if (sb_q.size() == 0) begin
        check("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("data", 64'(data_o), 64'(e.d));
        check("zero", 64'(zero_o), 64'(e.z));
        check("illegal", 64'(illegal_o), 64'(e.il));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_issue", 64'(ready_o), 64'd1);
    alu_ctrl = op;
    d1       = a;
    d2       = b;
    valid_i  = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int nv;
    int n_low;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_zero", 64'(zero_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(ready_o), 64'd1);
    repeat (2) @(negedge clk);
    check("idle_valid", 64'(valid_o), 64'd0);
    check("idle_data", 64'(data_o), 64'd0);

    // Back-to-back single-cycle ops
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    issue(ALU_SUB, 32'd5, 32'd5);
    issue(ALU_AND, 32'hF0F0, 32'h0FF0);
    issue(ALU_OR, 32'h1, 32'h2);
    issue(ALU_SUB, 32'd0, 32'd1);
    issue(3'd6, 32'd9, 32'd9);
    issue(ALU_ADD, 32'd1, 32'd2);
    drain();

    // Reset beats a simultaneous request
    @(posedge clk);
    #1;
    nv       = n_valid;
    rst_i    = 1'b1;
    valid_i  = 1'b1;
    alu_ctrl = ALU_ADD;
    d1       = 32'd5;
    d2       = 32'd5;
    @(posedge clk);
    #1 rst_i = 1'b0;
    valid_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wins_no_valid", 64'(n_valid), 64'(nv));
    check("rst_wins_data", 64'(data_o), 64'd0);

`ifdef ALU_EXEC_MUL_EN
    // MUL 7x6 with valid_i held high for a following ADD
    alu_ctrl = ALU_MUL;
    d1       = 32'd7;
    d2       = 32'd6;
    valid_i  = 1'b1;
    sb_q.push_back(model(ALU_MUL, 32'd7, 32'd6));
    @(posedge clk);
    #1;
    alu_ctrl = ALU_ADD;
    d1       = 32'd1;
    d2       = 32'd1;
    sb_q.push_back(model(ALU_ADD, 32'd1, 32'd1));
    n_low = 0;
    @(negedge clk);
    while (!ready_o && n_low < 100) begin
      n_low++;
      @(negedge clk);
    end
    check("mul_ready_low_cycles", 64'(n_low), 64'(W));
    check("mul_valid_latency", 64'(valid_o), 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
    drain();

    issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // MUL aborted by reset ten cycles after accept
    alu_ctrl = ALU_MUL;
    d1       = 32'd3;
    d2       = 32'd4;
    valid_i  = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    nv = n_valid;
    repeat (9) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_data", 64'(data_o), 64'd0);
    check("abort_valid", 64'(valid_o), 64'd0);
    issue(ALU_ADD, 32'd2, 32'd2);
    drain();
    check("abort_one_valid", 64'(n_valid), 64'(nv + 1));
`else
    issue(ALU_MUL, 32'd3, 32'd3);
    @(negedge clk);
    check("mul_off_no_stall", 64'(ready_o), 64'd1);
    check("mul_off_valid", 64'(valid_o), 64'd1);
    drain();
`endif

    for (int i = 0; i < 10; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, $urandom, (i % 3 == 0) ? 32'd0 : $urandom);
    end
    drain();
    repeat (3) @(negedge clk);
    check("final_queue", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
